// File: rtl/up_down_counter4_pkg.sv
// Shared constants and types for the loadable up/down counter.
package up_down_counter4_pkg;

  localparam int unsigned COUNT_W = 4;

  typedef logic [COUNT_W-1:0] count_t;

endpackage : up_down_counter4_pkg

// File: rtl/up_down_counter4.sv
// Loadable up/down binary counter, WIDTH bits, wrapping modulo 2^WIDTH.
module up_down_counter4
  import up_down_counter4_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  // Load outranks stepping; up_down=1 steps down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else if (enable) begin
      if (up_down) begin
        count <= count - 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule : up_down_counter4

// File: tb/tb_up_down_counter4.sv
// Self-checking bench for up_down_counter4: directed sequences, a vector table and random traffic.
module tb_up_down_counter4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] data_in;
  logic [3:0] count;

  int unsigned total;
  int unsigned bad;
  int unsigned ref_val;

  typedef struct {
    logic       ld;
    logic       en;
    logic       ud;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [15];

  up_down_counter4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .up_down (up_down),
    .load    (load),
    .data_in (data_in),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the next rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ld, input logic en, input logic ud,
                              input logic [3:0] din, input logic [3:0] exp);
    vec_t v;
    v.ld = ld; v.en = en; v.ud = ud; v.din = din; v.exp = exp;
    return v;
  endfunction

  // Reference: plain modular arithmetic on the counter value.
  function automatic int unsigned model_next(input int unsigned cur, input logic ld,
                                             input logic en, input logic ud,
                                             input logic [3:0] din);
    if (ld) return int'(din);
    if (!en) return cur;
    if (ud) return (cur + 16 - 1) % 16;
    return (cur + 1) % 16;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp4;
    total = 0;
    bad   = 0;

    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 4'h3, 4'h3);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 4'hA, 4'hA);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 4'hB);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 4'h7, 4'h7);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 4'h2, 4'h7);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 4'h5, 4'h7);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 4'h8, 4'h8);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h9);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 4'hA);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 4'h0, 4'h9);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 4'h0, 4'h8);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h8);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 4'h0, 4'hF);

    // Reset held with enable high: count stays 0.
    rst_n = 1'b0; enable = 1'b1; up_down = 1'b0; load = 1'b0; data_in = 4'h0;
    #2;
    check("reset_async", count, 4'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_hold", count, 4'h0);
    end
    rst_n = 1'b1;

    // Up count with wrap F->0.
    for (int unsigned i = 1; i <= 20; i++) begin
      step();
      exp4 = 4'((i) % 16);
      check("up_count", count, exp4);
    end

    // One more step to 5, then reset mid-cycle must clear before the next edge.
    step();
    check("up_to_5", count, 4'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_midcycle", count, 4'h0);
    #1;
    rst_n = 1'b1;

    // Down count from 0 with wrap 0->F.
    up_down = 1'b1;
    for (int unsigned i = 1; i <= 18; i++) begin
      step();
      exp4 = 4'((16 * 2 - i) % 16);
      check("down_count", count, exp4);
    end

    // Vector table: load priority, load while disabled, direction switch, wraps.
    for (int i = 0; i < 15; i++) begin
      load = vecs[i].ld; enable = vecs[i].en; up_down = vecs[i].ud; data_in = vecs[i].din;
      step();
      check($sformatf("vec%0d", i), count, vecs[i].exp);
    end

    // Random traffic against the arithmetic model, with occasional async resets.
    ref_val = int'(count);
    for (int i = 0; i < 300; i++) begin
      load    = ($urandom_range(7) == 0);
      enable  = 1'($urandom);
      up_down = 1'($urandom);
      data_in = 4'($urandom);
      ref_val = model_next(ref_val, load, enable, up_down, data_in);
      step();
      exp4 = 4'(ref_val);
      check("random", count, exp4);
      if ($urandom_range(39) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        ref_val = 0;
        check("random_reset", count, 4'h0);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_up_down_counter4
